// File: rtl/gemini_ifu_pkg.sv
// gemini_ifu_pkg: shared fetch-unit sizing, entry layout and reset PC
package gemini_ifu_pkg;
  localparam int IFQ_DEPTH = 4;
  localparam int PTR_W = $clog2(IFQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PC_W = 32;
  localparam int INST_W = 32;
  localparam int FILLED_W = 1;
  localparam logic [PC_W-1:0] RESET_PC = 32'hbfc0_0000;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic [FILLED_W-1:0] filled;
  } ifq_entry_t;
endpackage

// File: rtl/ifq_storage.sv
// ifq_storage: fetch-queue entry array; pc written on accept, inst on fill,
// async read of the head entry.
module ifq_storage
  import gemini_ifu_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int PW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [PW-1:0]     wptr_i,
  input  logic [PC_W-1:0]   wpc_i,
  input  logic              fill_i,
  input  logic [PW-1:0]     fptr_i,
  input  logic [INST_W-1:0] finst_i,
  input  logic              pop_i,
  input  logic [PW-1:0]     rptr_i,
  output logic [PC_W-1:0]   rd_pc_o,
  output logic [INST_W-1:0] rd_inst_o,
  output logic              rd_filled_o
);
  ifq_entry_t ent_q [DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en_i && wptr_i == PW'(i)) ent_q[i].pc <= wpc_i;
        if (fill_i && fptr_i == PW'(i)) ent_q[i].inst <= finst_i;
        ent_q[i].filled <= clr_i ? 1'b0 :
                           (fill_i && fptr_i == PW'(i)) ? 1'b1 :
                           (pop_i && rptr_i == PW'(i)) ? 1'b0 : ent_q[i].filled;
      end
    end
  assign rd_pc_o = ent_q[rptr_i].pc;
  assign rd_inst_o = ent_q[rptr_i].inst;
  assign rd_filled_o = ent_q[rptr_i].filled[0];
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: issues PC fetches on the instruction bus, tracks in-flight
// requests, and hands returned words to decode in order.
module inst_fetch_queue
  import gemini_ifu_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              flush_i,
  output logic              pc_stall_o,
  output logic              inst_req_o,
  output logic [PC_W-1:0]   inst_addr_o,
  input  logic              inst_addr_ok_i,
  input  logic              inst_data_ok_i,
  input  logic [INST_W-1:0] inst_rdata_i,
  output logic              out_valid_o,
  output logic [PC_W-1:0]   out_pc_o,
  output logic [INST_W-1:0] out_inst_o,
  input  logic              out_ready_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] wptr_q, wptr_d, fptr_q, fptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d, pend_q, pend_d, drop_q, drop_d;
  logic accept, fill, pop;
  assign inst_req_o = rst_n & ~flush_i & (cnt_q != CW'(DEPTH));
  assign inst_addr_o = pc_i;
  assign accept = inst_req_o & inst_addr_ok_i;
  assign pc_stall_o = ~accept;
  assign fill = inst_data_ok_i & (drop_q == '0) & ~flush_i;
  assign pop = out_valid_o & out_ready_i & ~flush_i;
  // pend_q counts allocated-but-unfilled entries; on flush they become words to drop
  always_comb begin
    wptr_d = flush_i ? '0 : wptr_q + PW'(accept);
    fptr_d = flush_i ? '0 : fptr_q + PW'(fill);
    rptr_d = flush_i ? '0 : rptr_q + PW'(pop);
    cnt_d = flush_i ? '0 : cnt_q + CW'(accept) - CW'(pop);
    pend_d = flush_i ? '0 : pend_q + CW'(accept) - CW'(fill);
    drop_d = flush_i ? drop_q + pend_q - CW'(inst_data_ok_i) :
                       drop_q - CW'(inst_data_ok_i && drop_q != '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q <= '0;
      fptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      pend_q <= '0;
      drop_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      fptr_q <= fptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
    end
  ifq_storage #(.DEPTH(DEPTH), .PW(PW)) u_storage (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (flush_i),
    .wr_en_i     (accept),
    .wptr_i      (wptr_q),
    .wpc_i       (pc_i),
    .fill_i      (fill),
    .fptr_i      (fptr_q),
    .finst_i     (inst_rdata_i),
    .pop_i       (pop),
    .rptr_i      (rptr_q),
    .rd_pc_o     (out_pc_o),
    .rd_inst_o   (out_inst_o),
    .rd_filled_o (out_valid_o)
  );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed vector table, random bus scoreboard and
// async-reset sequence for inst_fetch_queue.
module tb_inst_fetch_queue;
  import gemini_ifu_pkg::*;
  localparam logic [31:0] B = RESET_PC;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, aok = 1'b0, dok = 1'b0, rdy = 1'b0;
  logic [31:0] pc = '0, rdata = '0;
  logic pc_stall, inst_req, out_valid;
  logic [31:0] inst_addr, out_pc, out_inst;
  int total = 0, passed = 0;
  typedef struct {
    logic [31:0] pc;
    logic fl, a, d;
    logic [31:0] rd;
    logic y, req, stall, vld;
    logic [31:0] opc, oinst;
  } vec_t;
  vec_t tv[$];
  logic [31:0] bq[$], sb[$];
  inst_fetch_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_i           (pc),
    .flush_i        (flush),
    .pc_stall_o     (pc_stall),
    .inst_req_o     (inst_req),
    .inst_addr_o    (inst_addr),
    .inst_addr_ok_i (aok),
    .inst_data_ok_i (dok),
    .inst_rdata_i   (rdata),
    .out_valid_o    (out_valid),
    .out_pc_o       (out_pc),
    .out_inst_o     (out_inst),
    .out_ready_i    (rdy)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask
  task automatic drive(logic [31:0] p, logic f, logic a, logic d, logic [31:0] r, logic y);
    @(negedge clk);
    pc = p; flush = f; aok = a; dok = d; rdata = r; rdy = y;
    #1;
  endtask
  function automatic vec_t mk(logic [31:0] p, logic f, logic a, logic d, logic [31:0] r, logic y,
                              logic req, logic st, logic v, logic [31:0] opc, logic [31:0] oi);
    vec_t t;
    t.pc = p; t.fl = f; t.a = a; t.d = d; t.rd = r; t.y = y;
    t.req = req; t.stall = st; t.vld = v; t.opc = opc; t.oinst = oi;
    return t;
  endfunction
  function automatic logic [31:0] word_of(logic [31:0] a);
    return a ^ 32'h5a5a_a5a5;
  endfunction
  initial begin
    logic a, d, y, acc;
    logic [31:0] rpc;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_inst", out_inst, 0);
    chk("rst_req", inst_req, 0);
    chk("rst_stall", pc_stall, 1);
    @(negedge clk);
    rst_n = 1'b1;
    // zero-wait streaming
    tv.push_back(mk(B+0,   0,1,0,0,1,            1,0,0,0,0));
    tv.push_back(mk(B+4,   0,1,1,32'hA0000000,1, 1,0,0,0,0));
    tv.push_back(mk(B+8,   0,1,1,32'hA0000004,1, 1,0,1,B+0,32'hA0000000));
    tv.push_back(mk(B+'hc, 0,0,1,32'hA0000008,1, 1,1,1,B+4,32'hA0000004));
    tv.push_back(mk(B+'hc, 0,0,0,0,1,            1,1,1,B+8,32'hA0000008));
    tv.push_back(mk(B+'hc, 0,0,0,0,1,            1,1,0,0,0));
    // fill to full with decode stalled
    tv.push_back(mk(B+'hc, 0,1,0,0,0,            1,0,0,0,0));
    tv.push_back(mk(B+'h10,0,1,1,32'hB0,0,       1,0,0,0,0));
    tv.push_back(mk(B+'h14,0,1,1,32'hB1,0,       1,0,1,B+'hc,32'hB0));
    tv.push_back(mk(B+'h18,0,1,1,32'hB2,0,       1,0,1,B+'hc,32'hB0));
    tv.push_back(mk(B+'h1c,0,1,1,32'hB3,0,       0,1,1,B+'hc,32'hB0));
    tv.push_back(mk(B+'h1c,0,1,0,0,1,            0,1,1,B+'hc,32'hB0));
    tv.push_back(mk(B+'h1c,0,1,0,0,0,            1,0,1,B+'h10,32'hB1));
    tv.push_back(mk(B+'h20,0,1,0,0,1,            0,1,1,B+'h10,32'hB1));
    tv.push_back(mk(B+'h20,0,1,0,0,1,            1,0,1,B+'h14,32'hB2));
    tv.push_back(mk(B+'h24,0,1,0,0,0,            1,0,1,B+'h18,32'hB3));
    // flush with 3 outstanding and out_ready high
    tv.push_back(mk(B+'h28,1,1,0,0,1,            0,1,1,B+'h18,32'hB3));
    tv.push_back(mk(B+'h28,0,1,1,32'h11111111,1, 1,0,0,0,0));
    tv.push_back(mk(B+'h2c,0,0,1,32'h22222222,1, 1,1,0,0,0));
    tv.push_back(mk(B+'h2c,0,0,1,32'h33333333,1, 1,1,0,0,0));
    tv.push_back(mk(B+'h2c,0,0,1,32'hC0000028,1, 1,1,0,0,0));
    tv.push_back(mk(B+'h2c,0,0,0,0,1,            1,1,1,B+'h28,32'hC0000028));
    tv.push_back(mk(B+'h2c,0,0,0,0,1,            1,1,0,0,0));
    // flush coinciding with data_ok, 2 outstanding
    tv.push_back(mk(B+'h2c,0,1,0,0,1,            1,0,0,0,0));
    tv.push_back(mk(B+'h30,0,1,0,0,1,            1,0,0,0,0));
    tv.push_back(mk(B+'h34,1,1,1,32'hD1,1,       0,1,0,0,0));
    tv.push_back(mk(B+'h34,0,1,1,32'hD2,1,       1,0,0,0,0));
    tv.push_back(mk(B+'h38,0,0,1,32'hD0000034,1, 1,1,0,0,0));
    tv.push_back(mk(B+'h38,0,0,0,0,1,            1,1,1,B+'h34,32'hD0000034));
    tv.push_back(mk(B+'h38,0,0,0,0,1,            1,1,0,0,0));
    foreach (tv[k]) begin
      drive(tv[k].pc, tv[k].fl, tv[k].a, tv[k].d, tv[k].rd, tv[k].y);
      chk($sformatf("v%0d_req", k), inst_req, tv[k].req);
      chk($sformatf("v%0d_stall", k), pc_stall, tv[k].stall);
      chk($sformatf("v%0d_addr", k), inst_addr, tv[k].pc);
      chk($sformatf("v%0d_valid", k), out_valid, tv[k].vld);
      if (tv[k].vld) begin
        chk($sformatf("v%0d_pc", k), out_pc, tv[k].opc);
        chk($sformatf("v%0d_inst", k), out_inst, tv[k].oinst);
      end
    end
    // random bus and decode timing against an in-order scoreboard
    rpc = 32'h8000_0000;
    for (int c = 0; c < 460; c++) begin
      logic [31:0] r;
      a = c < 400 ? 1'($urandom_range(0, 1)) : 1'b0;
      d = bq.size() > 0 && $urandom_range(0, 1) == 1;
      y = c < 400 ? 1'($urandom_range(0, 1)) : 1'b1;
      r = d ? word_of(bq[0]) : 32'h0;
      drive(rpc, 0, a, d, r, y);
      chk("rnd_req", inst_req, sb.size() != 4);
      chk("rnd_stall", pc_stall, !(sb.size() != 4 && a));
      acc = inst_req & a;
      if (out_valid && y) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL rnd_pop: out_valid with nothing outstanding, pc %h", out_pc);
        end else begin
          chk("rnd_pc", out_pc, sb[0]);
          chk("rnd_inst", out_inst, word_of(sb[0]));
          sb.pop_front();
        end
      end
      @(posedge clk);
      if (d) bq.pop_front();
      if (acc) begin
        bq.push_back(rpc);
        sb.push_back(rpc);
        rpc += 4;
      end
    end
    chk("rnd_drained", 32'(sb.size()), 0);
    // async reset with 2 filled and 1 outstanding
    drive(32'hE0, 0, 1, 0, 0, 0);
    drive(32'hE4, 0, 1, 1, 32'hF0, 0);
    drive(32'hE8, 0, 1, 1, 32'hF4, 0);
    drive(32'hEC, 0, 0, 0, 0, 0);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_pc", out_pc, 32'hE0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_stall", pc_stall, 1);
    chk("arst_req", inst_req, 0);
    chk("arst_pc", out_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h1000, 0, 1, 0, 0, 1);
    chk("post_req", inst_req, 1);
    chk("post_stall", pc_stall, 0);
    drive(32'h1004, 0, 0, 1, 32'hFEED0001, 1);
    chk("post_valid0", out_valid, 0);
    drive(32'h1004, 0, 0, 0, 0, 1);
    chk("post_valid1", out_valid, 1);
    chk("post_pc", out_pc, 32'h1000);
    chk("post_inst", out_inst, 32'hFEED0001);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
